// File: rtl/pipe_skid_reg_pkg.sv
// Shared types for the elastic pipeline-stage register: FSM state encoding,
// per-stage payload layouts and their flush masks.
package pipe_skid_reg_pkg;

  // Encoding doubles as the held-beat count, so occupancy is a direct decode.
  typedef enum logic [1:0] {
    PIPE_EMPTY = 2'd0,
    PIPE_ONE   = 2'd1,
    PIPE_FULL  = 2'd2
  } pipe_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_payload_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [10:0] ctrl;
  } id_ex_payload_t;

  typedef struct packed {
    logic [31:0] pc_nxt;
    logic [31:0] alu_result;
    logic [31:0] rs2_val;
    logic [4:0]  rd;
    logic [2:0]  mem_op;
  } ex_mem_payload_t;

  typedef struct packed {
    logic [31:0] pc_nxt;
    logic [31:0] alu_result;
  } mem_wb_payload_t;

  localparam int IF_ID_W  = $bits(if_id_payload_t);
  localparam int ID_EX_W  = $bits(id_ex_payload_t);
  localparam int EX_MEM_W = $bits(ex_mem_payload_t);
  localparam int MEM_WB_W = $bits(mem_wb_payload_t);

  // A flushed instruction word reads as zero so a stray issue is harmless.
  localparam logic [IF_ID_W-1:0]  IF_ID_FLUSH_MASK  = {32'h0, 32'hFFFF_FFFF};
  localparam logic [ID_EX_W-1:0]  ID_EX_FLUSH_MASK  = {128'h0, 5'h1F, 11'h7FF};
  localparam logic [EX_MEM_W-1:0] EX_MEM_FLUSH_MASK = {32'hFFFF_FFFF, 32'h0, 32'h0, 5'h1F, 3'h7};
  localparam logic [MEM_WB_W-1:0] MEM_WB_FLUSH_MASK = {32'hFFFF_FFFF, 32'h0};

  function automatic logic [1:0] pipe_occupancy(input pipe_state_e s);
    case (s)
      PIPE_ONE:  return 2'd1;
      PIPE_FULL: return 2'd2;
      default:   return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/dff_sr_wrap.sv
// Enable flop with optional synchronous active-high reset; RST_EN=0 leaves
// the register unreset so it can map onto plain flops.
module dff_sr_wrap #(
  parameter int               WIDTH   = 1,
  parameter bit               RST_EN  = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (RST_EN && rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register with valid/ready on both sides, optional
// 2-entry skid buffer (registered in_ready) and masked synchronous flush.
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int               WIDTH         = 32,
  parameter bit               SKID          = 1'b1,
  parameter logic [WIDTH-1:0] FLUSH_MASK    = '0,
  parameter bit               RESET_PAYLOAD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  logic [1:0]       r_state_bits;
  pipe_state_e      w_state;
  pipe_state_e      w_state_nxt;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] w_m_d;
  logic [WIDTH-1:0] w_s_d;
  logic             w_m_en;
  logic             w_s_en;
  logic             r_rdy;
  logic             w_rdy_nxt;
  logic             w_out_valid;
  logic             w_in_fire;
  logic             w_out_fire;

  function automatic logic [WIDTH-1:0] flush_clear(input logic [WIDTH-1:0] v);
    return v & ~FLUSH_MASK;
  endfunction

  assign w_state     = pipe_state_e'(r_state_bits);
  assign w_out_valid = (w_state != PIPE_EMPTY);

  // Skid mode drives in_ready straight from a flop; otherwise it looks through to out_ready.
  assign in_ready   = ~rst & (SKID ? r_rdy : (~w_out_valid | out_ready));
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = w_out_valid & out_ready;

  always_comb begin
    w_state_nxt = w_state;
    w_m_en      = 1'b0;
    w_m_d       = in_data;
    w_s_en      = 1'b0;
    w_s_d       = in_data;
    if (flush) begin
      w_state_nxt = PIPE_EMPTY;
      w_m_en      = 1'b1;
      w_m_d       = flush_clear(r_m);
      w_s_en      = SKID;
      w_s_d       = flush_clear(r_s);
    end else begin
      case (w_state)
        PIPE_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = PIPE_ONE;
            w_m_en      = 1'b1;
          end
        end
        PIPE_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_m_en = 1'b1;
          end else if (w_in_fire && SKID) begin
            w_state_nxt = PIPE_FULL;
            w_s_en      = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = PIPE_EMPTY;
          end
        end
        PIPE_FULL: begin
          if (w_out_fire) begin
            w_state_nxt = PIPE_ONE;
            w_m_en      = 1'b1;
            w_m_d       = r_s;
          end
        end
        default: w_state_nxt = PIPE_EMPTY;
      endcase
    end
    w_rdy_nxt = (w_state_nxt != PIPE_FULL);
  end

  dff_sr_wrap #(.WIDTH(2), .RST_EN(1'b1), .RST_VAL(2'(PIPE_EMPTY))) u_state (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (2'(w_state_nxt)),
    .q   (r_state_bits)
  );

  dff_sr_wrap #(.WIDTH(1), .RST_EN(1'b1), .RST_VAL(1'b1)) u_rdy (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .d   (w_rdy_nxt),
    .q   (r_rdy)
  );

  dff_sr_wrap #(.WIDTH(WIDTH), .RST_EN(RESET_PAYLOAD), .RST_VAL('0)) u_main (
    .clk (clk),
    .rst (rst),
    .en  (w_m_en),
    .d   (w_m_d),
    .q   (r_m)
  );

  dff_sr_wrap #(.WIDTH(WIDTH), .RST_EN(RESET_PAYLOAD), .RST_VAL('0)) u_skid (
    .clk (clk),
    .rst (rst),
    .en  (w_s_en),
    .d   (w_s_d),
    .q   (r_s)
  );

  assign out_valid = w_out_valid;
  assign out_data  = r_m;
  assign occupancy = pipe_occupancy(w_state);

  a_no_full_ready: assert property (@(posedge clk) disable iff (rst)
    !(occupancy == 2'd2 && in_ready));

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: vector table, directed flush/reset/ready-path
// sequences, then randomized traffic against a queue-based reference model.
module tb_pipe_skid_reg;

  localparam logic [63:0] SMASK = 64'hFFFF_FFFF_0000_0000;
  localparam logic [31:0] NMASK = 32'h0000_FFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush;
  logic        s_iv, s_ir, s_ov, s_ordy;
  logic [63:0] s_id, s_od;
  logic [1:0]  s_occ;
  logic        n_iv, n_ir, n_ov, n_ordy;
  logic [31:0] n_id, n_od;
  logic [1:0]  n_occ;

  pipe_skid_reg #(.WIDTH(64), .SKID(1'b1), .FLUSH_MASK(SMASK), .RESET_PAYLOAD(1'b1)) u_skid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(s_iv), .in_ready(s_ir), .in_data(s_id),
    .out_valid(s_ov), .out_ready(s_ordy), .out_data(s_od), .occupancy(s_occ)
  );

  pipe_skid_reg #(.WIDTH(32), .SKID(1'b0), .FLUSH_MASK(NMASK), .RESET_PAYLOAD(1'b1)) u_nskid (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(n_iv), .in_ready(n_ir), .in_data(n_id),
    .out_valid(n_ov), .out_ready(n_ordy), .out_data(n_od), .occupancy(n_occ)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_s(input logic iv, input logic [63:0] d, input logic ordy);
    s_iv = iv; s_id = d; s_ordy = ordy;
  endtask

  typedef struct {
    logic        rst;
    logic        iv;
    logic [63:0] d;
    logic        ordy;
    logic        e_ir;
    logic        e_ov;
    logic [63:0] e_od;
    logic [1:0]  e_occ;
  } vec_t;

  vec_t tbl [12];

  logic [63:0] q_s [$];
  logic [63:0] q_n [$];

  initial begin
    logic        m_s_ir, m_n_ir, m_s_ov, m_n_ov;
    logic        s_inf, s_outf, n_inf, n_outf;
    logic [31:0] head, dnext;

    tbl[0]  = '{1'b1, 1'b1, 64'h100, 1'b1, 1'b0, 1'b0, 64'h0,   2'd0};
    tbl[1]  = '{1'b0, 1'b1, 64'h100, 1'b1, 1'b1, 1'b0, 64'h0,   2'd0};
    tbl[2]  = '{1'b0, 1'b1, 64'h104, 1'b1, 1'b1, 1'b1, 64'h100, 2'd1};
    tbl[3]  = '{1'b0, 1'b1, 64'h108, 1'b1, 1'b1, 1'b1, 64'h104, 2'd1};
    tbl[4]  = '{1'b0, 1'b0, 64'h0,   1'b1, 1'b1, 1'b1, 64'h108, 2'd1};
    tbl[5]  = '{1'b0, 1'b1, 64'hA,   1'b0, 1'b1, 1'b0, 64'h0,   2'd0};
    tbl[6]  = '{1'b0, 1'b1, 64'hB,   1'b0, 1'b1, 1'b1, 64'hA,   2'd1};
    tbl[7]  = '{1'b0, 1'b1, 64'hC,   1'b0, 1'b0, 1'b1, 64'hA,   2'd2};
    tbl[8]  = '{1'b0, 1'b1, 64'hC,   1'b1, 1'b0, 1'b1, 64'hA,   2'd2};
    tbl[9]  = '{1'b0, 1'b1, 64'hC,   1'b1, 1'b1, 1'b1, 64'hB,   2'd1};
    tbl[10] = '{1'b0, 1'b0, 64'h0,   1'b1, 1'b1, 1'b1, 64'hC,   2'd1};
    tbl[11] = '{1'b0, 1'b0, 64'h0,   1'b1, 1'b1, 1'b0, 64'h0,   2'd0};

    rst = 1'b1; flush = 1'b0;
    drive_s(1'b0, 64'h0, 1'b0);
    n_iv = 1'b0; n_id = 32'h0; n_ordy = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      rst = tbl[i].rst;
      drive_s(tbl[i].iv, tbl[i].d, tbl[i].ordy);
      @(negedge clk);
      chk($sformatf("tbl%0d_in_ready", i), 64'(s_ir), 64'(tbl[i].e_ir));
      chk($sformatf("tbl%0d_out_valid", i), 64'(s_ov), 64'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_occupancy", i), 64'(s_occ), 64'(tbl[i].e_occ));
      if (tbl[i].e_ov) chk($sformatf("tbl%0d_out_data", i), s_od, tbl[i].e_od);
      tick();
    end

    // Flush from FULL: masked upper half cleared, incoming beat dropped.
    drive_s(1'b1, 64'h1234_5678_DEAD_BEEF, 1'b0); tick();
    drive_s(1'b1, 64'hCAFE_F00D_1111_2222, 1'b0); tick();
    drive_s(1'b1, 64'h5555_5555_5555_5555, 1'b0); flush = 1'b1;
    @(negedge clk);
    chk("full_occupancy", 64'(s_occ), 64'd2);
    chk("full_in_ready", 64'(s_ir), 64'd0);
    tick();
    flush = 1'b0; drive_s(1'b0, 64'h0, 1'b1);
    @(negedge clk);
    chk("flush_out_valid", 64'(s_ov), 64'd0);
    chk("flush_occupancy", 64'(s_occ), 64'd0);
    chk("flush_in_ready", 64'(s_ir), 64'd1);
    chk("flush_masked_data", s_od, 64'h0000_0000_DEAD_BEEF);
    tick();

    // Flush from ONE with a beat accepted in the same cycle.
    drive_s(1'b1, 64'h0000_0001_0000_0001, 1'b0); tick();
    drive_s(1'b1, 64'h9999_8888_7777_6666, 1'b1); flush = 1'b1;
    @(negedge clk);
    chk("flush1_in_ready", 64'(s_ir), 64'd1);
    chk("flush1_out_data", s_od, 64'h0000_0001_0000_0001);
    tick();
    flush = 1'b0; drive_s(1'b0, 64'h0, 1'b1);
    @(negedge clk);
    chk("flush1_out_valid_a", 64'(s_ov), 64'd0);
    chk("flush1_masked_data", s_od, 64'h0000_0000_0000_0001);
    tick();
    @(negedge clk);
    chk("flush1_out_valid_b", 64'(s_ov), 64'd0);
    tick();

    // Reset overrides flush and handshake.
    drive_s(1'b1, 64'hABCD, 1'b0); tick();
    rst = 1'b1; flush = 1'b1; drive_s(1'b1, 64'hEEEE, 1'b1);
    @(negedge clk);
    chk("rstflush_in_ready", 64'(s_ir), 64'd0);
    tick();
    rst = 1'b0; flush = 1'b0; drive_s(1'b0, 64'h0, 1'b0);
    @(negedge clk);
    chk("rstflush_out_valid", 64'(s_ov), 64'd0);
    chk("rstflush_occupancy", 64'(s_occ), 64'd0);
    chk("rstflush_payload", s_od, 64'd0);
    chk("rstflush_in_ready_after", 64'(s_ir), 64'd1);
    tick();

    // Single-entry mode: in_ready follows out_ready combinationally.
    n_iv = 1'b1; n_id = 32'd1; n_ordy = 1'b0;
    @(negedge clk);
    chk("n_empty_in_ready", 64'(n_ir), 64'd1);
    tick();
    head = 32'd1; dnext = 32'd2;
    for (int k = 0; k < 8; k++) begin
      n_ordy = (k % 2 == 0);
      n_id = dnext;
      @(negedge clk);
      chk($sformatf("n_ready_path%0d", k), 64'(n_ir), 64'(n_ordy));
      chk($sformatf("n_valid%0d", k), 64'(n_ov), 64'd1);
      chk($sformatf("n_data%0d", k), 64'(n_od), 64'(head));
      tick();
      if (n_ordy) begin
        head = dnext;
        dnext = dnext + 32'd1;
      end
    end

    // Randomized traffic against queue models.
    q_s.delete(); q_n.delete();
    for (int c = 0; c < 10000; c++) begin
      rst    = (c < 2) || ($urandom_range(0, 499) == 0);
      flush  = !rst && ($urandom_range(0, 19) == 0);
      s_iv   = 1'($urandom_range(0, 1));
      s_ordy = 1'($urandom_range(0, 1));
      s_id   = {$urandom, $urandom};
      n_iv   = 1'($urandom_range(0, 1));
      n_ordy = 1'($urandom_range(0, 1));
      n_id   = $urandom;
      @(negedge clk);
      m_s_ir = !rst && (q_s.size() < 2);
      m_s_ov = (q_s.size() > 0);
      m_n_ir = !rst && ((q_n.size() == 0) || n_ordy);
      m_n_ov = (q_n.size() > 0);
      if (c >= 2) begin
        chk("rnd_s_in_ready", 64'(s_ir), 64'(m_s_ir));
        chk("rnd_s_out_valid", 64'(s_ov), 64'(m_s_ov));
        chk("rnd_s_occupancy", 64'(s_occ), 64'(q_s.size()));
        if (m_s_ov) chk("rnd_s_out_data", s_od, q_s[0]);
        chk("rnd_n_in_ready", 64'(n_ir), 64'(m_n_ir));
        chk("rnd_n_out_valid", 64'(n_ov), 64'(m_n_ov));
        chk("rnd_n_occupancy", 64'(n_occ), 64'(q_n.size()));
        if (m_n_ov) chk("rnd_n_out_data", 64'(n_od), q_n[0]);
      end
      s_inf  = s_iv && m_s_ir;
      s_outf = m_s_ov && s_ordy;
      n_inf  = n_iv && m_n_ir;
      n_outf = m_n_ov && n_ordy;
      @(posedge clk);
      if (rst || flush) begin
        q_s.delete();
        q_n.delete();
      end else begin
        if (s_outf) void'(q_s.pop_front());
        if (s_inf) q_s.push_back(s_id);
        if (n_outf) void'(q_n.pop_front());
        if (n_inf) q_n.push_back(64'(n_id));
      end
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
